// File: rtl/counter_cmd_driver.sv
// Command sequencer for the 3-bit load/increment counter: buffers LOAD / INC-by-N commands
// and expands each into ld/inc strobes (first strobe 2 cycles after accept); cmd_ready_o drops when the FIFO is full.
module counter_cmd_driver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3,
   parameter int REP_W = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic             cmd_op_i,
   input  logic [REP_W-1:0] cmd_arg_i,
   input  logic             pause_i,
   output logic             ld_o,
   output logic             inc_o,
   output logic [CNT_W-1:0] data_in_o,
   output logic [CNT_W-1:0] expected_o,
   output logic             busy_o,
   output logic             cmd_done_o,
   output logic [AW:0]      fifo_count_o
);

   typedef enum logic [1:0] {IDLE, ISSUE_LD, ISSUE_INC} state_t;

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [REP_W:0]   mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   state_t           state_q, state_d;
   logic [REP_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] data_in_q, data_in_d;
   logic [CNT_W-1:0] expected_q;
   logic             done_q, done_d;
   logic             push, pop;
   logic             head_op;
   logic [REP_W-1:0] head_arg;

   assign push     = cmd_valid_i & cmd_ready_o;
   assign head_op  = mem_q[rd_ptr_q][REP_W];
   assign head_arg = mem_q[rd_ptr_q][REP_W-1:0];

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Storage is not reset; emptiness is carried entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {cmd_op_i, cmd_arg_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         state_q    <= IDLE;
         rem_q      <= '0;
         data_in_q  <= '0;
         expected_q <= '0;
         done_q     <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q   <= count_d;
         state_q   <= state_d;
         rem_q     <= rem_d;
         data_in_q <= data_in_d;
         done_q    <= done_d;
         if (ld_o)
            expected_q <= data_in_q;
         else if (inc_o)
            expected_q <= expected_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      data_in_d = data_in_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pop) begin
               if (!head_op) begin
                  data_in_d = head_arg[CNT_W-1:0];
                  state_d   = ISSUE_LD;
               end else if (head_arg != '0) begin
                  rem_d   = head_arg;
                  state_d = ISSUE_INC;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ISSUE_LD: begin
            if (!pause_i) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         ISSUE_INC: begin
            if (!pause_i) begin
               rem_d = rem_q - REP_W'(1);
               if (rem_q == REP_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are masked by rst so a reset landing mid-command never reaches the counter.
   always_comb begin
      pop         = (state_q == IDLE) && (count_q != '0);
      ld_o        = !rst && (state_q == ISSUE_LD) && !pause_i;
      inc_o       = !rst && (state_q == ISSUE_INC) && !pause_i;
      busy_o      = (state_q != IDLE) || (count_q != '0);
      cmd_ready_o = !rst && (count_q < FULL);
   end

   assign data_in_o    = data_in_q;
   assign expected_o   = expected_q;
   assign cmd_done_o   = done_q;
   assign fifo_count_o = count_q;

endmodule
